// File: rtl/id_operand_fetch.sv
// id_operand_fetch: register file read with writeback bypass, operand forming, and ID/EX pipeline register
module id_operand_fetch #(
    parameter logic [31:0] NOP_INST   = 32'h00000013,
    parameter bit          REG_RST_EN = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] inst_i,
    input  logic        inst_valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);
    localparam logic [6:0] OP_IALU = 7'b0010011;
    logic [31:0] regs [32];
    logic        wr;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_val, rs2_val, op2_val;
    logic        hold_op1_wb, hold_op2_wb;
    assign wr = wb_we_i && (wb_waddr_i != 5'd0);
    assign rs1 = inst_i[19:15];
    assign rs2 = inst_i[24:20];
    assign rs1_val = (wr && wb_waddr_i == rs1) ? wb_wdata_i : (rs1 == 5'd0 ? 32'd0 : regs[rs1]);
    assign rs2_val = (wr && wb_waddr_i == rs2) ? wb_wdata_i : (rs2 == 5'd0 ? 32'd0 : regs[rs2]);
    assign op2_val = (inst_i[6:0] == OP_IALU) ? {{20{inst_i[31]}}, inst_i[31:20]} : rs2_val;
    assign hold_op1_wb = wr && (wb_waddr_i == inst_o[19:15]);
    assign hold_op2_wb = wr && (wb_waddr_i == inst_o[24:20]) && (inst_o[6:0] != OP_IALU);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (REG_RST_EN)
                for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
        end else if (wr) begin
            regs[wb_waddr_i] <= wb_wdata_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || (!stall_i && !inst_valid_i)) begin
            valid_o <= 1'b0;
            inst_o  <= NOP_INST;
            op1_o   <= 32'd0;
            op2_o   <= 32'd0;
        end else if (stall_i) begin
            // a held instruction must still see results written back while it waits
            if (hold_op1_wb) op1_o <= wb_wdata_i;
            if (hold_op2_wb) op2_o <= wb_wdata_i;
        end else begin
            valid_o <= 1'b1;
            inst_o  <= inst_i;
            op1_o   <= rs1_val;
            op2_o   <= op2_val;
        end
    end
endmodule

// File: tb/tb_id_operand_fetch.sv
// tb_id_operand_fetch: random and directed stimulus against a behavioural operand-fetch model
module tb_id_operand_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        iv, st, fl, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] op1, op2, inst_q;
    logic        valid;
    int checks = 0;
    int errors = 0;
    logic        chk_on = 1'b0;
    logic [31:0] mx [32];
    logic [31:0] m_op1, m_op2, m_inst;
    logic        m_v;

    id_operand_fetch dut (
        .clk_i(clk), .rst_i(rst), .inst_i(inst), .inst_valid_i(iv), .stall_i(st), .flush_i(fl),
        .wb_we_i(we), .wb_waddr_i(wa), .wb_wdata_i(wd),
        .op1_o(op1), .op2_o(op2), .inst_o(inst_q), .valid_o(valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd(input logic [4:0] a);
        if (a == 0) return 32'd0;
        if (we && wa == a) return wd;
        return mx[a];
    endfunction

    function automatic bit is_ialu(input logic [31:0] i);
        return i[6:0] == 7'h13;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_v = 0; m_inst = 32'h13; m_op1 = 0; m_op2 = 0;
            for (int i = 0; i < 32; i++) mx[i] = 0;
            return;
        end
        if (fl || (!st && !iv)) begin
            m_v = 0; m_inst = 32'h13; m_op1 = 0; m_op2 = 0;
        end else if (st) begin
            if (we && wa != 0 && wa == m_inst[19:15]) m_op1 = wd;
            if (we && wa != 0 && wa == m_inst[24:20] && !is_ialu(m_inst)) m_op2 = wd;
        end else begin
            m_v = 1; m_inst = inst; m_op1 = rd(inst[19:15]);
            m_op2 = is_ialu(inst) ? 32'(signed'(inst[31:20])) : rd(inst[24:20]);
        end
        if (we && wa != 0) mx[wa] = wd;
    endtask

    task automatic step(input logic r, input logic [31:0] i, input logic v, input logic s,
                        input logic f, input logic w, input logic [4:0] a, input logic [31:0] d);
        rst = r; inst = i; iv = v; st = s; fl = f; we = w; wa = a; wd = d;
        @(posedge clk);
        model_edge();
        if (r) chk_on = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("op1", op1, m_op1);
            chk("op2", op2, m_op2);
            chk("inst", inst_q, m_inst);
            chk("valid", {31'd0, valid}, {31'd0, m_v});
        end
    end

    initial begin
        step(1, 32'h006281B3, 1, 0, 0, 1, 5'd5, 32'h1);
        step(1, 32'h006281B3, 1, 0, 0, 1, 5'd6, 32'h2);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_inst", inst_q, 32'h13);
        chk("rst_op1", op1, 32'd0);
        chk("rst_op2", op2, 32'd0);
        step(0, 32'h006281B3, 1, 0, 0, 0, 0, 0);
        chk("rst_read_op1", op1, 32'd0);
        chk("rst_read_op2", op2, 32'd0);
        step(0, 0, 0, 0, 0, 1, 5'd5, 32'h00001234);
        step(0, 0, 0, 0, 0, 1, 5'd6, 32'hFFFFFFFF);
        step(0, 32'h006281B3, 1, 0, 0, 0, 0, 0);
        chk("add_op1", op1, 32'h00001234);
        chk("add_op2", op2, 32'hFFFFFFFF);
        chk("add_inst", inst_q, 32'h006281B3);
        chk("add_valid", {31'd0, valid}, 32'd1);
        step(0, 32'h006281B3, 1, 0, 0, 1, 5'd5, 32'h000000AA);
        chk("bypass_op1", op1, 32'h000000AA);
        step(0, 32'h006281B3, 1, 0, 0, 0, 0, 0);
        chk("after_bypass_op1", op1, 32'h000000AA);
        step(0, 0, 0, 0, 0, 1, 5'd0, 32'hDEADBEEF);
        step(0, 32'h00500033, 1, 0, 0, 0, 0, 0);
        chk("x0_op1", op1, 32'd0);
        step(0, 0, 0, 0, 0, 1, 5'd2, 32'd7);
        step(0, 32'hFFF10093, 1, 0, 0, 0, 0, 0);
        chk("addi_op1", op1, 32'd7);
        chk("addi_op2", op2, 32'hFFFFFFFF);
        step(0, 32'h006281B3, 1, 0, 0, 0, 0, 0);
        step(0, 32'hFFF10093, 1, 1, 0, 1, 5'd6, 32'h55);
        chk("stall_op2", op2, 32'h55);
        chk("stall_op1", op1, 32'h000000AA);
        chk("stall_inst", inst_q, 32'h006281B3);
        chk("stall_valid", {31'd0, valid}, 32'd1);
        step(0, 32'hFFF10093, 1, 1, 1, 0, 0, 0);
        chk("flush_valid", {31'd0, valid}, 32'd0);
        chk("flush_inst", inst_q, 32'h13);
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ri;
            ri = $urandom;
            ri[6:0] = ($urandom_range(0, 1) == 0) ? 7'h13 : 7'h33;
            step($urandom_range(0, 99) == 0, ri, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
